quadrature_generator: RTL

- Synthesises quadrature A/B/I waveforms from a commanded signed position.
- Steps one quadrature edge at a time toward a target, at a programmable rate.
- Used for encoder emulation and hardware-in-loop test of the encoder peripheral on the uniboard.
- Its A/B sequence counts up in the existing quadrature decoder when moving forward.

---
 rtl/quadrature_generator_pkg.sv | 24 ++
 rtl/quadrature_generator_index_counter.sv | 39 +++
 rtl/quadrature_generator.sv | 100 ++++++++++
 3 files changed

// File: rtl/quadrature_generator_pkg.sv
// Shared quadrature definitions: FSM states, phase-to-AB table and the
// forward-direction convention used by both the generator and the decoder.
package quadrature_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Forward (+1) counts up in the decoder and means A leads B.
  localparam logic DIR_UP = 1'b1;

  // {A,B} for a given position[1:0]
  function automatic logic [1:0] phase_ab(input logic [1:0] ph);
    case (ph)
      2'd0:    phase_ab = 2'b00;
      2'd1:    phase_ab = 2'b10;
      2'd2:    phase_ab = 2'b11;
      default: phase_ab = 2'b01;
    endcase
  endfunction

endpackage

// File: rtl/quadrature_generator_index_counter.sv
// Up/down modulo-INDEX_CPR counter; I is high when the count is zero.
module quadrature_index_counter
  import quadrature_generator_pkg::*;
#(
  parameter int INDEX_CPR = 2048
) (
  input  logic                         clk_12MHz,
  input  logic                         reset,
  input  logic                         step,
  input  logic                         dir,
  output logic [$clog2(INDEX_CPR)-1:0] index_ctr,
  output logic                         I
);

  localparam int CW = $clog2(INDEX_CPR);
  localparam logic [CW-1:0] TOP = CW'(INDEX_CPR - 1);

  logic [CW-1:0] ctr_nxt;

  // Wrap by comparison so non-power-of-two CPR works without a divider.
  always_comb begin
    ctr_nxt = index_ctr;
    if (step) begin
      if (dir == DIR_UP) ctr_nxt = (index_ctr == TOP) ? '0 : index_ctr + CW'(1);
      else               ctr_nxt = (index_ctr == '0) ? TOP : index_ctr - CW'(1);
    end
  end

  always_ff @(posedge clk_12MHz) begin
    if (!reset) begin
      index_ctr <= '0;
      I         <= 1'b1;
    end else begin
      index_ctr <= ctr_nxt;
      I         <= (ctr_nxt == '0);
    end
  end

endmodule

// File: rtl/quadrature_generator.sv
// Quadrature A/B/I generator: steps one edge at a time toward a commanded
// signed target at a programmable period.
module quadrature_generator
  import quadrature_generator_pkg::*;
#(
  parameter int COUNT_W   = 32,
  parameter int PERIOD_W  = 16,
  parameter int INDEX_CPR = 2048
) (
  input  logic                       clk_12MHz,
  input  logic                       reset,
  input  logic signed [COUNT_W-1:0]  target_count,
  input  logic        [PERIOD_W-1:0] period,
  input  logic                       load,
  input  logic                       stop,
  output logic                       busy,
  output logic                       done,
  output logic signed [COUNT_W-1:0]  position,
  output logic                       A,
  output logic                       B,
  output logic                       I
);

  state_t                      state;
  logic signed [COUNT_W-1:0]   tgt;
  logic        [PERIOD_W-1:0]  per, timer, per_in;
  logic signed [COUNT_W-1:0]   pos_nxt;
  logic                        dir_up, step;
  logic [$clog2(INDEX_CPR)-1:0] index_ctr;

  assign per_in  = (period == '0) ? PERIOD_W'(1) : period;
  assign dir_up  = (tgt > position);
  assign pos_nxt = dir_up ? position + COUNT_W'(1) : position - COUNT_W'(1);
  // Load and stop take priority, so a step never coincides with either.
  assign step    = (state == ST_RUN) && !stop && !load && (timer == '0);

  quadrature_index_counter #(.INDEX_CPR(INDEX_CPR)) u_idx (
    .clk_12MHz (clk_12MHz),
    .reset     (reset),
    .step      (step),
    .dir       (dir_up ? DIR_UP : ~DIR_UP),
    .index_ctr (index_ctr),
    .I         (I)
  );

  always_ff @(posedge clk_12MHz) begin
    if (!reset) begin
      state    <= ST_IDLE;
      position <= '0;
      tgt      <= '0;
      per      <= PERIOD_W'(1);
      timer    <= '0;
      {A, B}   <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Aborting drops any coincident load; outputs stay where they are.
        if (state != ST_IDLE) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      end else if (load) begin
        tgt   <= target_count;
        per   <= per_in;
        timer <= per_in - PERIOD_W'(1);
        if (target_count == position) begin
          state <= ST_DONE;
          busy  <= 1'b0;
        end else begin
          state <= ST_RUN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          ST_RUN: begin
            if (timer != '0) begin
              timer <= timer - PERIOD_W'(1);
            end else begin
              position <= pos_nxt;
              {A, B}   <= phase_ab(pos_nxt[1:0]);
              timer    <= per - PERIOD_W'(1);
              if (pos_nxt == tgt) begin
                state <= ST_DONE;
                busy  <= 1'b0;
              end
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
